handshaking_slave_fifo: RTL and testbench
=========================================

HANDSHAKING_SLAVE_FIFO -- requirements
Module: handshaking_slave_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data bit width (legal: >= 1).
REQ-002 Parameter DEPTH, default 4, SHALL set the buffer entry count (legal: power of two, >= 2).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 data_in  input  DATA_WIDTH  SHALL be the upstream payload.
REQ-006 data_valid  input  1  SHALL mark data_in as valid.
REQ-007 ready  input  1  SHALL be the local receive enable; it is registered before use.
REQ-008 data_ready  output  1  SHALL signal that the block accepts data this cycle.
REQ-009 data_out  output  DATA_WIDTH  SHALL be the downstream payload, the oldest stored entry.
REQ-010 out_valid  output  1  SHALL mark data_out as valid.
REQ-011 out_ready  input  1  SHALL be the downstream acceptance.
REQ-012 clear  input  1  SHALL synchronously empty the buffer.
REQ-013 count  output  $clog2(DEPTH+1)  SHALL report the current occupancy.

Function
REQ-014 en_q SHALL be a registered copy of ready, giving one cycle of lag from ready to data_ready.
REQ-015 data_ready SHALL equal en_q AND NOT full (combinational from registers only, no input-to-output path).
REQ-016 push SHALL occur when data_valid AND data_ready.
- data_in is written at wr_ptr.
- wr_ptr increments modulo DEPTH.
REQ-017 out_valid SHALL equal NOT empty.
REQ-018 data_out SHALL equal mem[rd_ptr], stable while out_valid AND NOT out_ready.
REQ-019 pop SHALL occur when out_valid AND out_ready; rd_ptr increments modulo DEPTH.
REQ-020 Latency SHALL be one cycle from push to out_valid; there is no bypass when empty.
REQ-021 count SHALL update as follows:
- push only: +1.
- pop only: -1.
- both or neither: unchanged.
REQ-022 full SHALL be count == DEPTH; empty SHALL be count == 0.
REQ-023 Push while full SHALL be impossible, because data_ready is low.
REQ-024 Pop while empty SHALL be impossible, because out_valid is low.
REQ-025 Simultaneous push and pop at any non-full, non-empty occupancy SHALL both take effect with count unchanged.
REQ-026 Pointer wrap from DEPTH-1 to 0 SHALL be seamless.
REQ-027 clear SHALL take priority over push and pop in the same cycle.
- Resulting state: count=0, wr_ptr=0, rd_ptr=0.
- en_q still follows ready.
- Memory contents are not cleared.
REQ-028 Data SHALL leave in exactly the order it was accepted, with no loss or duplication.

Reset
REQ-029 On rst high at a clock edge the block SHALL set en_q=0, wr_ptr=0, rd_ptr=0, count=0.
- Resulting outputs: data_ready=0, out_valid=0, count=0.
REQ-030 data_out SHALL read 0 after reset: the memory is zeroed on reset.
REQ-031 rst asserted mid-transfer SHALL discard all buffered data and override clear, push and pop.

Structure
REQ-032 Shared package hs_pkg SHALL hold the default constants HS_DATA_WIDTH=8 and HS_DEPTH=4; no typedefs are needed.
REQ-033 Storage SHALL be one sub-module hs_fifo_mem (DEPTH x DATA_WIDTH register array, synchronous write, asynchronous read, synchronous zeroing on rst).
REQ-034 Pointer, count and handshake control logic SHALL reside in handshaking_slave_fifo.

Verification
REQ-035 Reset and enable lag: rst=1 for 2 cycles, then ready=1 -> data_ready=0 in the first cycle, 1 in the next; out_valid=0, count=0 throughout.
REQ-036 Fill to full, DEPTH=4, out_ready=0: push 0x11,0x22,0x33,0x44 -> count=4, data_ready=0; a fifth data_valid with 0x55 is not accepted.
REQ-037 Drain and order: from REQ-036, out_ready=1 -> data_out 0x11,0x22,0x33,0x44 on consecutive cycles, then out_valid=0, count=0.
REQ-038 Simultaneous push/pop with wrap: continuous stream of 0x00..0x0F, data_valid=out_ready=1 -> output equals input delayed 1 cycle; count stays 1; pointers wrap 4 times.
REQ-039 clear priority: count=3, then clear=1 with data_valid=out_ready=1 -> next cycle count=0, out_valid=0, no entry accepted or popped.
REQ-040 Mid-operation reset: count=2 plus push in progress, then rst=1 -> next cycle count=0, out_valid=0, data_ready=0, data_out=0.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared default sizing for the handshaking slave FIFO and its storage.
package hs_pkg;
    localparam int HS_DATA_WIDTH = 8;
    localparam int HS_DEPTH      = 4;
endpackage

// File: rtl/hs_fifo_mem.sv
// Register-array storage: synchronous write, asynchronous read, zeroed on reset
// so that data_out reads 0 immediately after reset.
module hs_fifo_mem
    import hs_pkg::*;
#(
    parameter int DATA_WIDTH = HS_DATA_WIDTH,
    parameter int DEPTH      = HS_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    mem_q[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/handshaking_slave_fifo.sv
// Valid/ready slave FIFO with registered receive enable; data_ready and out_valid
// depend on registers only, so there is no input-to-output combinational path.
module handshaking_slave_fifo
    import hs_pkg::*;
#(
    parameter int DATA_WIDTH = HS_DATA_WIDTH,
    parameter int DEPTH      = HS_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         data_valid,
    input  logic                         ready,
    output logic                         data_ready,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         clear,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic             en_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, push, pop;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign data_ready = en_q && !full;
    assign out_valid  = !empty;
    assign count      = count_q;

    // clear suppresses both handshakes so nothing is written or consumed that cycle
    assign push = data_valid && data_ready && !clear;
    assign pop  = out_valid && out_ready && !clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            en_q     <= ready;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    hs_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q),
        .rd_data (data_out)
    );
endmodule

// File: tb/tb_handshaking_slave_fifo.sv
// Directed scenarios for the handshaking slave FIFO at its default 8x4 size.
module tb_handshaking_slave_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       ready;
    logic       data_ready;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       clear;
    logic [2:0] count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    handshaking_slave_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .ready      (ready),
        .data_ready (data_ready),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clear      (clear),
        .count      (count)
    );

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b0; data_valid = 1'b0; data_in = 8'h00;
        out_ready = 1'b0; clear = 1'b0;
        tick(); tick();
        rst = 1'b0; ready = 1'b1;
        tests_run++;
        if (data_ready !== 1'b0 || out_valid !== 1'b0 || count !== 3'd0 || data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_state: data_ready=%b out_valid=%b count=%0d data_out=%h, want 0 0 0 00",
                     data_ready, out_valid, count, data_out);
        end
        tick();
        tests_run++;
        if (data_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
            tests_failed++;
            $display("FAIL enable_lag: data_ready=%b out_valid=%b count=%0d, want 1 0 0",
                     data_ready, out_valid, count);
        end
    endtask

    task automatic test_fill();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in = vals[i]; data_valid = 1'b1;
            tick();
            tests_run++;
            if (count !== 3'(i + 1) || out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL fill_%0d: count=%0d out_valid=%b, want %0d 1", i, count, out_valid, i + 1);
            end
        end
        tests_run++;
        if (data_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_ready: data_ready=%b, want 0", data_ready);
        end
        data_in = 8'h55;
        tick();
        data_valid = 1'b0;
        tests_run++;
        if (count !== 3'd4 || data_out !== 8'h11) begin
            tests_failed++;
            $display("FAIL push_when_full: count=%0d data_out=%h, want 4 11", count, data_out);
        end
    endtask

    task automatic test_drain();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || data_out !== vals[i]) begin
                tests_failed++;
                $display("FAIL drain_%0d: out_valid=%b data_out=%h, want 1 %h", i, out_valid, data_out, vals[i]);
            end
            tick();
        end
        tests_run++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            tests_failed++;
            $display("FAIL drain_empty: out_valid=%b count=%0d, want 0 0", out_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        data_valid = 1'b1; out_ready = 1'b1; data_in = 8'h00;
        tick();
        tests_run++;
        if (count !== 3'd1 || out_valid !== 1'b1 || data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL stream_first: count=%0d out_valid=%b data_out=%h, want 1 1 00", count, out_valid, data_out);
        end
        for (int i = 1; i < 16; i++) begin
            data_in = 8'(i);
            tick();
            tests_run++;
            if (count !== 3'd1 || data_out !== 8'(i)) begin
                tests_failed++;
                $display("FAIL stream_%0d: count=%0d data_out=%h, want 1 %h", i, count, data_out, 8'(i));
            end
        end
        data_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_end: count=%0d out_valid=%b, want 0 0", count, out_valid);
        end
    endtask

    task automatic test_clear();
        out_ready = 1'b0; data_valid = 1'b1;
        data_in = 8'hA1; tick();
        data_in = 8'hA2; tick();
        data_in = 8'hA3; tick();
        tests_run++;
        if (count !== 3'd3) begin
            tests_failed++;
            $display("FAIL clear_setup: count=%0d, want 3", count);
        end
        clear = 1'b1; data_in = 8'hEE; out_ready = 1'b1;
        tick();
        clear = 1'b0; data_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if (count !== 3'd0 || out_valid !== 1'b0 || data_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_priority: count=%0d out_valid=%b data_ready=%b, want 0 0 1",
                     count, out_valid, data_ready);
        end
        // A fresh push must land in entry 0 and be read back from entry 0.
        data_valid = 1'b1; data_in = 8'hB1;
        tick();
        data_valid = 1'b0;
        tests_run++;
        if (count !== 3'd1 || data_out !== 8'hB1) begin
            tests_failed++;
            $display("FAIL clear_ptrs: count=%0d data_out=%h, want 1 b1", count, data_out);
        end
    endtask

    task automatic test_mid_reset();
        data_valid = 1'b1; data_in = 8'hB2;
        tick();
        tests_run++;
        if (count !== 3'd2) begin
            tests_failed++;
            $display("FAIL midrst_setup: count=%0d, want 2", count);
        end
        data_in = 8'hB3; rst = 1'b1; clear = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; clear = 1'b0; data_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if (count !== 3'd0 || out_valid !== 1'b0 || data_ready !== 1'b0 || data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_reset: count=%0d out_valid=%b data_ready=%b data_out=%h, want 0 0 0 00",
                     count, out_valid, data_ready, data_out);
        end
        tick();
        tests_run++;
        if (data_ready !== 1'b1 || count !== 3'd0) begin
            tests_failed++;
            $display("FAIL post_reset_ready: data_ready=%b count=%0d, want 1 0", data_ready, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_clear();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
